cmd_cfg: RTL
============

Name: cmd_cfg

Overview:
- Command sequencer between the UART command receiver and the flight controller inside QuadCopter.
- Decodes each received 8-bit command and 16-bit data word, updates the desired pitch/roll/yaw/thrust setpoints, and runs the inertial calibration handshake.
- Controls the motors-off state and returns a one-byte acknowledge through the UART response path.
- A command watchdog forces an emergency land if the wireless link goes silent.

Parameters:
- WDOG_W, 26: watchdog counter width; timeout at 2^WDOG_W-1 clocks (~1.34 s at 50 MHz).
- ACK, 8'hA5: response byte for an accepted command.
- NAK, 8'hEE: response byte for an unknown opcode.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset; asynchronous, active-low
- cmd_rdy  input  1  level; a command/data pair is valid, held until cleared
- cmd  input  8  opcode
- data  input  16  command payload
- clr_cmd_rdy  output  1  one-cycle pulse; command consumed
- resp  output  8  response byte
- send_resp  output  1  one-cycle pulse; start response transmission
- resp_sent  input  1  response transmission finished
- d_ptch  output  16  signed desired pitch
- d_roll  output  16  signed desired roll
- d_yaw  output  16  signed desired yaw
- thrst  output  9  unsigned desired thrust
- strt_cal  output  1  one-cycle pulse; start inertial calibration
- inertial_cal  output  1  high while calibration is in progress
- cal_done  input  1  calibration complete
- motors_off  output  1  forces all ESC speeds to zero

Behaviour:
- All outputs are registered.
- Reset values:
  - d_ptch, d_roll, d_yaw, thrst = 0
  - motors_off = 1
  - resp = 8'h00
  - send_resp, clr_cmd_rdy, strt_cal, inertial_cal = 0
  - watchdog count = 0
  - state = IDLE
- Opcodes:
  - 02 SET_PTCH: d_ptch <= data
  - 03 SET_ROLL: d_roll <= data
  - 04 SET_YAW: d_yaw <= data
  - 05 SET_THRST: thrst <= data[8:0]; data[15:9] ignored
  - 06 CALIBRATE
  - 07 EMER_LAND: d_ptch, d_roll, d_yaw, thrst <= 0
  - 08 MTRS_OFF: motors_off <= 1, thrst <= 0
  - any other value: no register change, resp = NAK
- States: IDLE, CAL_WAIT, RESP, RESP_WAIT.
- IDLE, cmd_rdy=1 at edge N:
  - setpoint write and clr_cmd_rdy pulse both visible in cycle N+1.
  - Opcode 06: motors_off <= 0, strt_cal pulses in N+1, inertial_cal <= 1, go to CAL_WAIT.
  - All other opcodes: resp <= ACK (or NAK), go to RESP.
- CAL_WAIT:
  - cal_done is sampled only in this state.
  - On cal_done: inertial_cal <= 0, resp <= ACK, go to RESP.
  - cal_done seen in any other state is ignored.
- RESP: send_resp high exactly one cycle, then go to RESP_WAIT.
- RESP_WAIT:
  - Hold until resp_sent, then go to IDLE.
  - resp_sent in the same cycle as send_resp is accepted (return to IDLE next edge).
- cmd_rdy asserted while not in IDLE: left pending, not cleared, processed on the first IDLE edge. No command is dropped.
- Latency: setpoint update 1 cycle after cmd_rdy seen in IDLE; send_resp 2 cycles after (non-calibrate).
- Watchdog:
  - Increments every cycle, saturating at max.
  - Cleared on every command accepted in IDLE.
  - On reaching max: the same zeroing as EMER_LAND applies once; motors_off unchanged; no response sent; count stays saturated until the next command.
- Simultaneous watchdog expiry and command acceptance: the command wins, the count clears, and no forced land occurs.
- rst_n low mid-operation (including during CAL_WAIT or RESP_WAIT): immediate return to reset values. strt_cal is not re-issued.

Optional Feature:
- Macro CMD_CFG_FAST_SIM_EN.
- Defined: the effective watchdog width is 9 (timeout 511 clocks) regardless of WDOG_W, for simulation.
- Undefined: the width is WDOG_W.
- No other behaviour differs.

Decomposition:
- Package cmd_cfg_pkg:
  - typedef enum logic [7:0] for opcodes (SET_PTCH..MTRS_OFF)
  - state enum
  - ACK/NAK defaults
  - the fast-sim watchdog width constant
- Shared with CommMaster and the testbenches.
- One natural sub-module: cmd_wdog (saturating watchdog counter, clear input, expire pulse output).

Test Plan:
1. Reset, then SET_PTCH data=16'h0020 -> d_ptch=16'h0020 one cycle after cmd_rdy; clr_cmd_rdy pulses once; send_resp with resp=8'hA5; other setpoints remain 0.
2. SET_THRST data=16'hFE4F -> thrst=9'h04F; CALIBRATE with cal_done 1000 cycles later -> motors_off falls in cycle N+1, strt_cal single pulse, inertial_cal high for 1000 cycles, ACK only after cal_done.
3. SET_ROLL 16'h0040, SET_YAW 16'h0060, then EMER_LAND -> roll/yaw go to the commanded values, then all four setpoints go to 0 with ACK; MTRS_OFF -> motors_off=1, thrst=0.
4. Opcode 8'h3C -> resp=8'hEE; no setpoint change; clr_cmd_rdy still pulses.
5. With CMD_CFG_FAST_SIM_EN, thrst=9'h04F and no commands for 511 clocks -> all setpoints go to 0 with no send_resp; a command landing on the expiry cycle -> its value persists and the forced land is suppressed.
6. Second cmd_rdy raised during RESP_WAIT -> processed immediately after resp_sent; assert rst_n low during CAL_WAIT -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/cmd_cfg_pkg.sv
// -----------------------------------------------------------------------------
// cmd_cfg_pkg
//   Shared definitions for the command sequencer (cmd_cfg), CommMaster and the
//   testbenches: opcode and state enums, default response bytes, watchdog
//   widths and a small opcode-classification helper.
// -----------------------------------------------------------------------------
package cmd_cfg_pkg;

    // Command opcodes understood by the sequencer.
    typedef enum logic [7:0] {
        SET_PTCH  = 8'h02,
        SET_ROLL  = 8'h03,
        SET_YAW   = 8'h04,
        SET_THRST = 8'h05,
        CALIBRATE = 8'h06,
        EMER_LAND = 8'h07,
        MTRS_OFF  = 8'h08
    } opcode_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CAL_WAIT  = 2'd1,
        RESP      = 2'd2,
        RESP_WAIT = 2'd3
    } state_e;

    // Default response bytes.
    localparam logic [7:0] ACK_BYTE = 8'hA5;
    localparam logic [7:0] NAK_BYTE = 8'hEE;

    // Watchdog widths: normal build and the shortened simulation build.
    localparam int DEF_WDOG_W      = 26;
    localparam int FAST_SIM_WDOG_W = 9;

    // True for any opcode the sequencer acts on; anything else is NAKed.
    function automatic logic is_known_op(input logic [7:0] op);
        case (op)
            SET_PTCH, SET_ROLL, SET_YAW, SET_THRST,
            CALIBRATE, EMER_LAND, MTRS_OFF: is_known_op = 1'b1;
            default:                        is_known_op = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cmd_cfg_wdog.sv
// -----------------------------------------------------------------------------
// cmd_wdog
//   Saturating command watchdog. Counts every clock, stops at all-ones, and
//   restarts from zero whenever clr is high. expire is high for the single
//   cycle whose clock edge moves the count onto its maximum, so the forced
//   land happens once per silent period.
//
// Ports:
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   clr     in   restart the count (a command was accepted)
//   expire  out  one-cycle pulse, the count reaches its maximum on this edge
// -----------------------------------------------------------------------------
module cmd_wdog #(
    parameter int W = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic expire
);

    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0] CNT_PRE = {{(W-1){1'b1}}, 1'b0};

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // clr has priority so a command landing on the expiry edge suppresses it.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (count_q != CNT_MAX) begin
            count_d = count_q + 1'b1;
        end
    end

    assign expire = !clr && (count_q == CNT_PRE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cmd_cfg.sv
// -----------------------------------------------------------------------------
// cmd_cfg
//   Command sequencer between the UART command receiver and the flight
//   controller. Decodes opcode/data pairs, maintains the pitch/roll/yaw/thrust
//   setpoints, runs the inertial calibration handshake, controls motors_off
//   and returns a one-byte ACK/NAK. A watchdog zeroes the setpoints if the
//   link goes silent.
//
// Build option:
//   CMD_CFG_FAST_SIM_EN  when defined the watchdog is 9 bits wide (511-clock
//                        timeout) whatever WDOG_W is set to.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   cmd_rdy, cmd, data   pending command (level, held until clr_cmd_rdy)
//   clr_cmd_rdy          one-cycle pulse, command consumed
//   resp, send_resp      response byte and its one-cycle send strobe
//   resp_sent            response transmission finished
//   d_ptch, d_roll, d_yaw (signed 16), thrst (unsigned 9)  setpoints
//   strt_cal, inertial_cal, cal_done   calibration handshake
//   motors_off           forces all ESC speeds to zero
// -----------------------------------------------------------------------------
module cmd_cfg
    import cmd_cfg_pkg::*;
#(
    parameter int         WDOG_W = DEF_WDOG_W,
    parameter logic [7:0] ACK    = ACK_BYTE,
    parameter logic [7:0] NAK    = NAK_BYTE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_rdy,
    input  logic [7:0]  cmd,
    input  logic [15:0] data,
    output logic        clr_cmd_rdy,
    output logic [7:0]  resp,
    output logic        send_resp,
    input  logic        resp_sent,
    output logic [15:0] d_ptch,
    output logic [15:0] d_roll,
    output logic [15:0] d_yaw,
    output logic [8:0]  thrst,
    output logic        strt_cal,
    output logic        inertial_cal,
    input  logic        cal_done,
    output logic        motors_off
);

`ifdef CMD_CFG_FAST_SIM_EN
    localparam int EFF_WDOG_W = FAST_SIM_WDOG_W;
`else
    localparam int EFF_WDOG_W = WDOG_W;
`endif

    state_e      state_q,        state_d;
    logic [15:0] d_ptch_q,       d_ptch_d;
    logic [15:0] d_roll_q,       d_roll_d;
    logic [15:0] d_yaw_q,        d_yaw_d;
    logic [8:0]  thrst_q,        thrst_d;
    logic        motors_off_q,   motors_off_d;
    logic [7:0]  resp_q,         resp_d;
    logic        send_resp_q,    send_resp_d;
    logic        clr_cmd_rdy_q,  clr_cmd_rdy_d;
    logic        strt_cal_q,     strt_cal_d;
    logic        inertial_cal_q, inertial_cal_d;

    logic        wdog_clr;
    logic        wdog_expire;

    cmd_wdog #(
        .W (EFF_WDOG_W)
    ) u_wdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (wdog_clr),
        .expire (wdog_expire)
    );

    // Next-state and output decode. The watchdog land is applied first so a
    // command decoded in the same cycle overrides it (the watchdog itself also
    // withholds expire when cleared, so the two never truly collide).
    always_comb begin
        state_d        = state_q;
        d_ptch_d       = d_ptch_q;
        d_roll_d       = d_roll_q;
        d_yaw_d        = d_yaw_q;
        thrst_d        = thrst_q;
        motors_off_d   = motors_off_q;
        resp_d         = resp_q;
        inertial_cal_d = inertial_cal_q;
        send_resp_d    = 1'b0;
        clr_cmd_rdy_d  = 1'b0;
        strt_cal_d     = 1'b0;
        wdog_clr       = 1'b0;

        if (wdog_expire) begin
            d_ptch_d = '0;
            d_roll_d = '0;
            d_yaw_d  = '0;
            thrst_d  = '0;
        end

        case (state_q)
            IDLE: begin
                if (cmd_rdy) begin
                    clr_cmd_rdy_d = 1'b1;
                    wdog_clr      = 1'b1;
                    case (cmd)
                        SET_PTCH:  d_ptch_d = data;
                        SET_ROLL:  d_roll_d = data;
                        SET_YAW:   d_yaw_d  = data;
                        SET_THRST: thrst_d  = data[8:0];
                        CALIBRATE: begin
                            motors_off_d   = 1'b0;
                            strt_cal_d     = 1'b1;
                            inertial_cal_d = 1'b1;
                        end
                        EMER_LAND: begin
                            d_ptch_d = '0;
                            d_roll_d = '0;
                            d_yaw_d  = '0;
                            thrst_d  = '0;
                        end
                        MTRS_OFF: begin
                            motors_off_d = 1'b1;
                            thrst_d      = '0;
                        end
                        default: ;
                    endcase
                    // Calibration defers its ACK until cal_done arrives.
                    if (cmd == CALIBRATE) begin
                        state_d = CAL_WAIT;
                    end else begin
                        resp_d  = is_known_op(cmd) ? ACK : NAK;
                        state_d = RESP;
                    end
                end
            end
            CAL_WAIT: begin
                if (cal_done) begin
                    inertial_cal_d = 1'b0;
                    resp_d         = ACK;
                    state_d        = RESP;
                end
            end
            RESP: begin
                send_resp_d = 1'b1;
                state_d     = RESP_WAIT;
            end
            RESP_WAIT: begin
                // resp_sent coinciding with send_resp is already in this state.
                if (resp_sent) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            d_ptch_q       <= '0;
            d_roll_q       <= '0;
            d_yaw_q        <= '0;
            thrst_q        <= '0;
            motors_off_q   <= 1'b1;
            resp_q         <= 8'h00;
            send_resp_q    <= 1'b0;
            clr_cmd_rdy_q  <= 1'b0;
            strt_cal_q     <= 1'b0;
            inertial_cal_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            d_ptch_q       <= d_ptch_d;
            d_roll_q       <= d_roll_d;
            d_yaw_q        <= d_yaw_d;
            thrst_q        <= thrst_d;
            motors_off_q   <= motors_off_d;
            resp_q         <= resp_d;
            send_resp_q    <= send_resp_d;
            clr_cmd_rdy_q  <= clr_cmd_rdy_d;
            strt_cal_q     <= strt_cal_d;
            inertial_cal_q <= inertial_cal_d;
        end
    end

    assign d_ptch       = d_ptch_q;
    assign d_roll       = d_roll_q;
    assign d_yaw        = d_yaw_q;
    assign thrst        = thrst_q;
    assign motors_off   = motors_off_q;
    assign resp         = resp_q;
    assign send_resp    = send_resp_q;
    assign clr_cmd_rdy  = clr_cmd_rdy_q;
    assign strt_cal     = strt_cal_q;
    assign inertial_cal = inertial_cal_q;

endmodule
